// File: rtl/gb_cpu_fetch_ctrl_if.sv
// Fetch-controller bus bundle: scheduler/decoder/bus inputs and the instruction-register side outputs.
// master drives the fetch inputs and observes the results; slave is the fetch controller itself.
interface gb_cpu_fetch_ctrl_if;
   logic [7:0] data_bus_i;
   logic       instr_done_i;
   logic       cb_prefix_i;
   logic       halt_req_i;
   logic       ime_i;
   logic [4:0] int_pending_i;
   logic [7:0] opcode_o;
   logic       cb_mode_o;
   logic       halted_o;
   logic       halt_bug_o;
   logic       int_dispatch_o;
   logic [2:0] dispatch_cycle_o;
   logic [7:0] int_vector_o;
   logic [4:0] int_ack_o;
   logic       ime_clear_o;

   modport master (
      output data_bus_i, instr_done_i, cb_prefix_i, halt_req_i, ime_i, int_pending_i,
      input  opcode_o, cb_mode_o, halted_o, halt_bug_o, int_dispatch_o,
             dispatch_cycle_o, int_vector_o, int_ack_o, ime_clear_o
   );

   modport slave (
      input  data_bus_i, instr_done_i, cb_prefix_i, halt_req_i, ime_i, int_pending_i,
      output opcode_o, cb_mode_o, halted_o, halt_bug_o, int_dispatch_o,
             dispatch_cycle_o, int_vector_o, int_ack_o, ime_clear_o
   );
endinterface

// File: rtl/gb_cpu_fetch_ctrl.sv
// Instruction register, CB mode, HALT and interrupt-dispatch sequencing; one clk edge per M-cycle.
// All outputs come from registers: opcode is valid the cycle after the instr_done edge.
module gb_cpu_fetch_ctrl #(
   parameter int         DISPATCH_CYCLES = 5,
   parameter logic [7:0] RESET_OPCODE    = 8'h00
) (
   input logic            clk,
   input logic            reset,
   gb_cpu_fetch_ctrl_if.slave bus
);

   typedef enum logic [1:0] {RUN, HALTED, DISPATCH} state_t;

   localparam logic [2:0] LAST_CYCLE = 3'(DISPATCH_CYCLES - 1);

   state_t     state_q, state_nxt;
   logic [7:0] opcode_q, opcode_d;
   logic       cb_mode_q, cb_mode_d;
   logic       halted_q, halted_d;
   logic       halt_bug_q, halt_bug_d;
   logic       dispatch_q, dispatch_d;
   logic [2:0] cycle_q, cycle_d;
   logic [7:0] vector_q, vector_d;
   logic [2:0] idx_q, idx_d;
   logic       pend_any;
   logic [2:0] pick;

   assign pend_any = |bus.int_pending_i;

   // Lowest set bit wins: VBlank has the highest priority.
   always_comb begin
      pick = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (bus.int_pending_i[i]) pick = 3'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         opcode_q   <= RESET_OPCODE;
         cb_mode_q  <= 1'b0;
         halted_q   <= 1'b0;
         halt_bug_q <= 1'b0;
         dispatch_q <= 1'b0;
         cycle_q    <= 3'd0;
         vector_q   <= 8'h00;
         idx_q      <= 3'd0;
      end else begin
         state_q    <= state_nxt;
         opcode_q   <= opcode_d;
         cb_mode_q  <= cb_mode_d;
         halted_q   <= halted_d;
         halt_bug_q <= halt_bug_d;
         dispatch_q <= dispatch_d;
         cycle_q    <= cycle_d;
         vector_q   <= vector_d;
         idx_q      <= idx_d;
      end
   end

   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         RUN: begin
            if (bus.instr_done_i) begin
               if (bus.halt_req_i) begin
                  if (!pend_any)      state_nxt = HALTED;
                  else if (bus.ime_i) state_nxt = DISPATCH;
               end else if (!bus.cb_prefix_i && bus.ime_i && pend_any) begin
                  state_nxt = DISPATCH;
               end
            end
         end
         HALTED: begin
            if (pend_any) state_nxt = bus.ime_i ? DISPATCH : RUN;
         end
         DISPATCH: begin
            if (cycle_q == LAST_CYCLE) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      opcode_d   = opcode_q;
      cb_mode_d  = cb_mode_q;
      halted_d   = halted_q;
      halt_bug_d = 1'b0;
      dispatch_d = dispatch_q;
      cycle_d    = cycle_q;
      vector_d   = vector_q;
      idx_d      = idx_q;
      unique case (state_q)
         RUN: begin
            // Staying in RUN after a HALT request is the halt bug: fetch anyway, freeze PC once.
            if (bus.instr_done_i && state_nxt == RUN) begin
               opcode_d   = bus.data_bus_i;
               cb_mode_d  = bus.cb_prefix_i;
               halt_bug_d = bus.halt_req_i;
            end
            if (state_nxt == HALTED) halted_d = 1'b1;
         end
         HALTED: begin
            if (state_nxt != HALTED) halted_d = 1'b0;
            if (state_nxt == RUN) begin
               opcode_d  = RESET_OPCODE;
               cb_mode_d = 1'b0;
            end
         end
         DISPATCH: begin
            if (cycle_q == LAST_CYCLE) begin
               opcode_d   = bus.data_bus_i;
               cb_mode_d  = 1'b0;
               dispatch_d = 1'b0;
               cycle_d    = 3'd0;
            end else begin
               cycle_d = cycle_q + 3'd1;
            end
         end
         default: ;
      endcase
      if (state_nxt == DISPATCH && state_q != DISPATCH) begin
         idx_d      = pick;
         vector_d   = 8'h40 + {2'b00, pick, 3'b000};
         dispatch_d = 1'b1;
         cycle_d    = 3'd0;
         opcode_d   = RESET_OPCODE;
         cb_mode_d  = 1'b0;
      end
   end

   assign bus.opcode_o         = opcode_q;
   assign bus.cb_mode_o        = cb_mode_q;
   assign bus.halted_o         = halted_q;
   assign bus.halt_bug_o       = halt_bug_q;
   assign bus.int_dispatch_o   = dispatch_q;
   assign bus.dispatch_cycle_o = cycle_q;
   assign bus.int_vector_o     = vector_q;
   assign bus.ime_clear_o      = dispatch_q && (cycle_q == 3'd0);
   assign bus.int_ack_o        = (dispatch_q && cycle_q == 3'd3) ? (5'b00001 << idx_q) : 5'b00000;

endmodule

// File: tb/tb_gb_cpu_fetch_ctrl.sv
// Directed bench for gb_cpu_fetch_ctrl: fetch, CB mode, dispatch, HALT wake, halt bug, reset abort.
module tb_gb_cpu_fetch_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;

   gb_cpu_fetch_ctrl_if bus ();

   gb_cpu_fetch_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.data_bus_i    = 8'h00;
      bus.instr_done_i  = 1'b0;
      bus.cb_prefix_i   = 1'b0;
      bus.halt_req_i    = 1'b0;
      bus.ime_i         = 1'b0;
      bus.int_pending_i = 5'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      total++; if (bus.opcode_o !== 8'h00) begin bad++; $display("FAIL reset_opcode got=%h exp=00", bus.opcode_o); end
      total++; if (bus.cb_mode_o !== 1'b0) begin bad++; $display("FAIL reset_cb got=%b exp=0", bus.cb_mode_o); end
      total++; if (bus.halted_o !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", bus.halted_o); end
      total++; if (bus.halt_bug_o !== 1'b0) begin bad++; $display("FAIL reset_halt_bug got=%b exp=0", bus.halt_bug_o); end
      total++; if (bus.int_dispatch_o !== 1'b0) begin bad++; $display("FAIL reset_dispatch got=%b exp=0", bus.int_dispatch_o); end
      total++; if (bus.dispatch_cycle_o !== 3'd0) begin bad++; $display("FAIL reset_cycle got=%0d exp=0", bus.dispatch_cycle_o); end
      total++; if (bus.int_vector_o !== 8'h00) begin bad++; $display("FAIL reset_vector got=%h exp=00", bus.int_vector_o); end
      total++; if (bus.int_ack_o !== 5'b0) begin bad++; $display("FAIL reset_ack got=%b exp=00000", bus.int_ack_o); end
      total++; if (bus.ime_clear_o !== 1'b0) begin bad++; $display("FAIL reset_ime_clear got=%b exp=0", bus.ime_clear_o); end
   endtask

   task automatic test_fetch();
      bus.instr_done_i = 1'b1;
      bus.data_bus_i   = 8'h3E;
      tick();
      total++; if (bus.opcode_o !== 8'h3E) begin bad++; $display("FAIL fetch_opcode got=%h exp=3e", bus.opcode_o); end
      total++; if (bus.cb_mode_o !== 1'b0) begin bad++; $display("FAIL fetch_cb got=%b exp=0", bus.cb_mode_o); end
      bus.instr_done_i = 1'b0;
      bus.data_bus_i   = 8'hFF;
      tick();
      total++; if (bus.opcode_o !== 8'h3E) begin bad++; $display("FAIL fetch_hold got=%h exp=3e", bus.opcode_o); end
   endtask

   task automatic test_cb_no_int();
      bus.instr_done_i  = 1'b1;
      bus.cb_prefix_i   = 1'b1;
      bus.data_bus_i    = 8'h37;
      bus.ime_i         = 1'b1;
      bus.int_pending_i = 5'b00001;
      tick();
      idle_inputs();
      total++; if (bus.opcode_o !== 8'h37) begin bad++; $display("FAIL cb_opcode got=%h exp=37", bus.opcode_o); end
      total++; if (bus.cb_mode_o !== 1'b1) begin bad++; $display("FAIL cb_mode got=%b exp=1", bus.cb_mode_o); end
      total++; if (bus.int_dispatch_o !== 1'b0) begin bad++; $display("FAIL cb_no_dispatch got=%b exp=0", bus.int_dispatch_o); end
   endtask

   task automatic test_dispatch();
      bus.ime_i         = 1'b1;
      bus.int_pending_i = 5'b10100;
      bus.instr_done_i  = 1'b1;
      bus.data_bus_i    = 8'hAA;
      tick();
      // Pending set changes mid-dispatch must not affect the latched index.
      bus.int_pending_i = 5'b00001;
      bus.instr_done_i  = 1'b0;
      bus.data_bus_i    = 8'hC3;
      total++; if (bus.int_dispatch_o !== 1'b1) begin bad++; $display("FAIL disp_c0_active got=%b exp=1", bus.int_dispatch_o); end
      total++; if (bus.dispatch_cycle_o !== 3'd0) begin bad++; $display("FAIL disp_c0_cycle got=%0d exp=0", bus.dispatch_cycle_o); end
      total++; if (bus.int_vector_o !== 8'h50) begin bad++; $display("FAIL disp_vector got=%h exp=50", bus.int_vector_o); end
      total++; if (bus.ime_clear_o !== 1'b1) begin bad++; $display("FAIL disp_ime_clear got=%b exp=1", bus.ime_clear_o); end
      total++; if (bus.opcode_o !== 8'h00) begin bad++; $display("FAIL disp_opcode_nop got=%h exp=00", bus.opcode_o); end
      total++; if (bus.int_ack_o !== 5'b0) begin bad++; $display("FAIL disp_c0_ack got=%b exp=00000", bus.int_ack_o); end
      for (int c = 1; c < 5; c++) begin
         tick();
         total++; if (bus.int_dispatch_o !== 1'b1) begin bad++; $display("FAIL disp_active c=%0d got=%b exp=1", c, bus.int_dispatch_o); end
         total++; if (bus.dispatch_cycle_o !== 3'(c)) begin bad++; $display("FAIL disp_cycle got=%0d exp=%0d", bus.dispatch_cycle_o, c); end
         total++; if (bus.ime_clear_o !== 1'b0) begin bad++; $display("FAIL disp_ime_clear c=%0d got=%b exp=0", c, bus.ime_clear_o); end
         total++; if (bus.int_ack_o !== ((c == 3) ? 5'b00100 : 5'b00000)) begin bad++; $display("FAIL disp_ack c=%0d got=%b", c, bus.int_ack_o); end
         total++; if (bus.int_vector_o !== 8'h50) begin bad++; $display("FAIL disp_vector_hold c=%0d got=%h exp=50", c, bus.int_vector_o); end
      end
      bus.ime_i         = 1'b0;
      bus.int_pending_i = 5'b0;
      tick();
      total++; if (bus.int_dispatch_o !== 1'b0) begin bad++; $display("FAIL disp_exit got=%b exp=0", bus.int_dispatch_o); end
      total++; if (bus.dispatch_cycle_o !== 3'd0) begin bad++; $display("FAIL disp_exit_cycle got=%0d exp=0", bus.dispatch_cycle_o); end
      total++; if (bus.opcode_o !== 8'hC3) begin bad++; $display("FAIL disp_isr_opcode got=%h exp=c3", bus.opcode_o); end
      total++; if (bus.int_vector_o !== 8'h50) begin bad++; $display("FAIL vector_after_exit got=%h exp=50", bus.int_vector_o); end
   endtask

   task automatic test_halt_wake();
      bus.halt_req_i    = 1'b1;
      bus.instr_done_i  = 1'b1;
      bus.int_pending_i = 5'b0;
      bus.data_bus_i    = 8'h76;
      tick();
      bus.halt_req_i = 1'b0;
      bus.data_bus_i = 8'h11;
      total++; if (bus.halted_o !== 1'b1) begin bad++; $display("FAIL halt_enter got=%b exp=1", bus.halted_o); end
      total++; if (bus.opcode_o !== 8'hC3) begin bad++; $display("FAIL halt_opcode_held got=%h exp=c3", bus.opcode_o); end
      for (int k = 0; k < 4; k++) begin
         tick();
         total++; if (bus.halted_o !== 1'b1 || bus.opcode_o !== 8'hC3) begin bad++; $display("FAIL halt_hold k=%0d halted=%b opcode=%h exp 1/c3", k, bus.halted_o, bus.opcode_o); end
      end
      bus.instr_done_i  = 1'b0;
      bus.int_pending_i = 5'b01000;
      bus.ime_i         = 1'b0;
      tick();
      bus.int_pending_i = 5'b0;
      total++; if (bus.halted_o !== 1'b0) begin bad++; $display("FAIL wake_halted got=%b exp=0", bus.halted_o); end
      total++; if (bus.opcode_o !== 8'h00) begin bad++; $display("FAIL wake_opcode got=%h exp=00", bus.opcode_o); end
      total++; if (bus.int_ack_o !== 5'b0 || bus.int_dispatch_o !== 1'b0) begin bad++; $display("FAIL wake_no_ack ack=%b disp=%b exp 00000/0", bus.int_ack_o, bus.int_dispatch_o); end
   endtask

   task automatic test_halt_bug();
      bus.halt_req_i    = 1'b1;
      bus.instr_done_i  = 1'b1;
      bus.ime_i         = 1'b0;
      bus.int_pending_i = 5'b00010;
      bus.data_bus_i    = 8'h04;
      tick();
      idle_inputs();
      total++; if (bus.halt_bug_o !== 1'b1) begin bad++; $display("FAIL bug_pulse got=%b exp=1", bus.halt_bug_o); end
      total++; if (bus.halted_o !== 1'b0) begin bad++; $display("FAIL bug_halted got=%b exp=0", bus.halted_o); end
      total++; if (bus.opcode_o !== 8'h04) begin bad++; $display("FAIL bug_opcode got=%h exp=04", bus.opcode_o); end
      tick();
      total++; if (bus.halt_bug_o !== 1'b0) begin bad++; $display("FAIL bug_one_cycle got=%b exp=0", bus.halt_bug_o); end
   endtask

   task automatic test_reset_mid_dispatch();
      // Enter dispatch by waking from HALT with IME set.
      bus.halt_req_i   = 1'b1;
      bus.instr_done_i = 1'b1;
      tick();
      idle_inputs();
      bus.ime_i         = 1'b1;
      bus.int_pending_i = 5'b00001;
      tick();
      total++; if (bus.int_dispatch_o !== 1'b1 || bus.halted_o !== 1'b0) begin bad++; $display("FAIL halt_ime_wake disp=%b halted=%b exp 1/0", bus.int_dispatch_o, bus.halted_o); end
      total++; if (bus.int_vector_o !== 8'h40) begin bad++; $display("FAIL halt_ime_vector got=%h exp=40", bus.int_vector_o); end
      tick();
      tick();
      total++; if (bus.dispatch_cycle_o !== 3'd2) begin bad++; $display("FAIL abort_pre_cycle got=%0d exp=2", bus.dispatch_cycle_o); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (bus.int_dispatch_o !== 1'b0) begin bad++; $display("FAIL abort_dispatch got=%b exp=0", bus.int_dispatch_o); end
      total++; if (bus.opcode_o !== 8'h00) begin bad++; $display("FAIL abort_opcode got=%h exp=00", bus.opcode_o); end
      total++; if (bus.dispatch_cycle_o !== 3'd0) begin bad++; $display("FAIL abort_cycle got=%0d exp=0", bus.dispatch_cycle_o); end
      total++; if (bus.int_vector_o !== 8'h00) begin bad++; $display("FAIL abort_vector got=%h exp=00", bus.int_vector_o); end
      for (int k = 0; k < 4; k++) begin
         total++; if (bus.int_ack_o !== 5'b0) begin bad++; $display("FAIL abort_ack k=%0d got=%b exp=00000", k, bus.int_ack_o); end
         tick();
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_fetch();
      test_cb_no_int();
      test_dispatch();
      test_halt_wake();
      test_halt_bug();
      test_reset_mid_dispatch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
